ifetch_buffer: RTL

- Consumer end of the fetch interface: accepts the valid/address stream from the fetch unit and issues synchronous reads to instruction memory.
- Captures returned instruction words, with their addresses, into a small FIFO that feeds decode.
- Drives the fetch-unit stall when buffer space (including in-flight reads) is exhausted.
- Discards all buffered and in-flight work on a branch flush.

---
 rtl/ifetch_buffer.sv | 106 ++++++++++
 1 files changed

// File: rtl/ifetch_buffer.sv
// Fetch-side instruction buffer: issues reads for the fetch address stream and queues
// the returned words with their addresses for decode. A branch flush discards everything.
module ifetch_buffer #(
    parameter int ADDR_W = 16,
    parameter int INSN_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              stall_o,
    input  logic              flush_i,
    output logic              imem_en_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [INSN_W-1:0] imem_data_i,
    output logic              out_v_o,
    input  logic              out_rdy_i,
    output logic [INSN_W-1:0] out_insn_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   FULL_LVL = (CNT_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              pend_v_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [INSN_W-1:0] insn_mem_r [DEPTH];
    logic [ADDR_W-1:0] addr_mem_r [DEPTH];

    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W:0]    reserved_s;

    // In-flight reads reserve a slot, so stall depends on registers only.
    assign reserved_s  = {1'b0, count_r} + {{CNT_W{1'b0}}, pend_v_r};
    assign stall_o     = (reserved_s >= FULL_LVL);
    assign issue_s     = v_i & ~stall_o & ~flush_i & rst;
    assign push_s      = pend_v_r & ~flush_i;
    assign out_v_o     = (count_r != {CNT_W{1'b0}}) & ~flush_i;
    assign pop_s       = out_v_o & out_rdy_i;

    assign imem_en_o   = issue_s;
    assign imem_addr_o = addr_i;
    assign out_insn_o  = insn_mem_r[rd_ptr_r];
    assign out_addr_o  = addr_mem_r[rd_ptr_r];

    // Pointers, occupancy and the one-cycle read-in-flight tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            pend_v_r    <= 1'b0;
            pend_addr_r <= {ADDR_W{1'b0}};
        end else if (flush_i) begin
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            pend_v_r    <= 1'b0;
            pend_addr_r <= addr_i;
        end else begin
            pend_v_r    <= issue_s;
            pend_addr_r <= addr_i;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; written only by a surviving response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                insn_mem_r[i] <= {INSN_W{1'b0}};
                addr_mem_r[i] <= {ADDR_W{1'b0}};
            end
        end else if (push_s) begin
            insn_mem_r[wr_ptr_r] <= imem_data_i;
            addr_mem_r[wr_ptr_r] <= pend_addr_r;
        end else begin
            insn_mem_r[wr_ptr_r] <= insn_mem_r[wr_ptr_r];
            addr_mem_r[wr_ptr_r] <= addr_mem_r[wr_ptr_r];
        end
    end

endmodule
